// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    FAULT
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD
  } pc_sel_t;

  localparam int unsigned PC_INCREMENT = 4;

  function automatic logic misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
interface fetch_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [31:0]           imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// Architectural next-fetch PC register with hold / increment / load select.
module fetch_pc_unit
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pc_sel_t               sel,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] pc
);

  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(PC_INCREMENT);

  // Increment wraps silently modulo 2^DATA_WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:  pc <= pc + INC;
        PC_LOAD: pc <= target;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch FSM with branch redirect and misalignment fault.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  fetch_sequencer_if.master     imem,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  decode_ready,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  fault
);

  fetch_state_t          state, state_next;
  pc_sel_t               pc_sel;
  logic                  capture;
  logic                  redirect_pending;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic [DATA_WIDTH-1:0] eff_target;
  logic                  eff_redirect;
  logic                  bad_target;

  // A same-cycle branch overrides any earlier latched target (last wins).
  assign eff_target   = branch_taken ? branch_target : redirect_target;
  assign eff_redirect = branch_taken | redirect_pending;
  assign bad_target   = misaligned(eff_target[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (branch_taken)  state_next = bad_target ? FAULT : IDLE;
        else if (!stall)   state_next = FETCH;
      end
      FETCH: begin
        if (imem.imem_ready) begin
          if (eff_redirect) state_next = bad_target ? FAULT : IDLE;
          else              state_next = VALID;
        end
      end
      VALID: begin
        if (branch_taken)      state_next = bad_target ? FAULT : IDLE;
        else if (decode_ready) state_next = stall ? IDLE : FETCH;
      end
      default: state_next = FAULT;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state == FETCH);
    imem.imem_addr = pc;
    instr_valid    = (state == VALID);
    fault          = (state == FAULT);
    pc_sel         = PC_HOLD;
    capture        = 1'b0;
    case (state)
      IDLE, VALID: begin
        if (branch_taken && !bad_target) pc_sel = PC_LOAD;
      end
      FETCH: begin
        if (imem.imem_ready) begin
          if (!eff_redirect)    begin pc_sel = PC_INC; capture = 1'b1; end
          else if (!bad_target) pc_sel = PC_LOAD;
        end
      end
      default: pc_sel = PC_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr            <= '0;
      instr_pc         <= '0;
      redirect_pending <= 1'b0;
      redirect_target  <= '0;
    end else begin
      if (capture) begin
        instr    <= imem.imem_rdata;
        instr_pc <= pc;
      end
      if (state == FETCH) begin
        if (branch_taken) redirect_target <= branch_target;
        if (imem.imem_ready)   redirect_pending <= 1'b0;
        else if (branch_taken) redirect_pending <= 1'b1;
      end
    end
  end

  fetch_pc_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .sel    (pc_sel),
    .target (eff_target),
    .pc     (pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Cycle vectors for fetch_sequencer plus a scoreboard of expected delivered instructions.
module tb_fetch_sequencer;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          bt;
    logic [31:0] tgt;
    bit          rdy;
    bit          dr;
    bit          push;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] ipc;
    logic [31:0] pc;
    bit          fault;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        rdy = 1'b0;
  logic        decode_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        fault;

  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;
  vec_t tbl[$];
  sb_t  sb[$];

  fetch_sequencer_if #(.DATA_WIDTH(32)) mif ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign mif.imem_ready = rdy;
  assign mif.imem_rdata = mem_word(mif.imem_addr);

  fetch_sequencer #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (mif),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .decode_ready  (decode_ready),
    .pc            (pc),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops one expected instruction on each rising edge of instr_valid.
  task automatic observe();
    sb_t e;
    if (instr_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got instr_valid with instr_pc %0h expected none", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", instr, e.word);
        chk("sb_instr_pc", instr_pc, e.pc);
      end
    end
    prev_valid = instr_valid;
  endtask

  task automatic do_reset();
    chk("sb_drained", sb.size(), 0);
    rst = 1'b0;
    stall = 1'b1;
    branch_taken = 1'b0;
    branch_target = '0;
    rdy = 1'b0;
    decode_ready = 1'b0;
    #1;
    chk("rst_req", mif.imem_req, 0);
    chk("rst_addr", mif.imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fault", fault, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    prev_valid = 1'b0;
  endtask

  function automatic vec_t R(bit r, bit s, bit b, logic [31:0] t, bit ry, bit d, bit p,
                             bit q, logic [31:0] a, bit v, logic [31:0] ip, logic [31:0] p2, bit f);
    vec_t x;
    x.rst = r; x.stall = s; x.bt = b; x.tgt = t; x.rdy = ry; x.dr = d; x.push = p;
    x.req = q; x.addr = a; x.valid = v; x.ipc = ip; x.pc = p2; x.fault = f;
    return x;
  endfunction

  initial begin
    //          rst st bt tgt           rdy dr push | req addr          vld ipc           pc            flt
    // zero-wait streaming 0x0, 0x4, 0x8, then stall on accept
    tbl.push_back(R(Y, N, N, 32'h0,        Y, Y, N,   N, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, Y,   Y, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, N,   N, 32'h4,        Y, 32'h0,        32'h4,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, Y,   Y, 32'h4,        N, 32'h0,        32'h4,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, N,   N, 32'h8,        Y, 32'h4,        32'h8,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, Y,   Y, 32'h8,        N, 32'h4,        32'h8,        N));
    tbl.push_back(R(N, Y, N, 32'h0,        Y, Y, N,   N, 32'hC,        Y, 32'h8,        32'hC,        N));
    tbl.push_back(R(N, Y, N, 32'h0,        Y, Y, N,   N, 32'hC,        N, 32'h8,        32'hC,        N));
    // memory ready after 3 wait cycles at 0x10, then decode back-pressure and stall on accept
    tbl.push_back(R(Y, Y, Y, 32'h10,       N, N, N,   N, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   N, 32'h10,       N, 32'h0,        32'h10,       N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   Y, 32'h10,       N, 32'h0,        32'h10,       N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   Y, 32'h10,       N, 32'h0,        32'h10,       N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   Y, 32'h10,       N, 32'h0,        32'h10,       N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, N, Y,   Y, 32'h10,       N, 32'h0,        32'h10,       N));
    for (int i = 0; i < 5; i++)
      tbl.push_back(R(N, N, N, 32'h0,      N, N, N,   N, 32'h14,       Y, 32'h10,       32'h14,       N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, Y, N,   N, 32'h14,       Y, 32'h10,       32'h14,       N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, N, N,   N, 32'h14,       N, 32'h10,       32'h14,       N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, N, N,   N, 32'h14,       N, 32'h10,       32'h14,       N));
    // redirect during pending fetch, last-wins, same-cycle redirect, VALID redirect priority
    tbl.push_back(R(Y, Y, Y, 32'h20,       N, N, N,   N, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   N, 32'h20,       N, 32'h0,        32'h20,       N));
    tbl.push_back(R(N, N, Y, 32'h100,      N, N, N,   Y, 32'h20,       N, 32'h0,        32'h20,       N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   Y, 32'h20,       N, 32'h0,        32'h20,       N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, N, N,   Y, 32'h20,       N, 32'h0,        32'h20,       N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, N, N,   N, 32'h100,      N, 32'h0,        32'h100,      N));
    tbl.push_back(R(N, Y, N, 32'h0,        Y, Y, Y,   Y, 32'h100,      N, 32'h0,        32'h100,      N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, Y, N,   N, 32'h104,      Y, 32'h100,      32'h104,      N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, N, N,   N, 32'h104,      N, 32'h100,      32'h104,      N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   N, 32'h104,      N, 32'h100,      32'h104,      N));
    tbl.push_back(R(N, N, Y, 32'h200,      N, N, N,   Y, 32'h104,      N, 32'h100,      32'h104,      N));
    tbl.push_back(R(N, N, Y, 32'h300,      N, N, N,   Y, 32'h104,      N, 32'h100,      32'h104,      N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, N, N,   Y, 32'h104,      N, 32'h100,      32'h104,      N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   N, 32'h300,      N, 32'h100,      32'h300,      N));
    tbl.push_back(R(N, N, Y, 32'h400,      Y, N, N,   Y, 32'h300,      N, 32'h100,      32'h300,      N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, N, N,   N, 32'h400,      N, 32'h100,      32'h400,      N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   N, 32'h400,      N, 32'h100,      32'h400,      N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, N, Y,   Y, 32'h400,      N, 32'h100,      32'h400,      N));
    tbl.push_back(R(N, N, Y, 32'h500,      N, Y, N,   N, 32'h404,      Y, 32'h400,      32'h404,      N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, N, N,   N, 32'h500,      N, 32'h400,      32'h500,      N));
    // misaligned redirect from IDLE is sticky until reset; misaligned latched redirect in FETCH
    tbl.push_back(R(Y, Y, Y, 32'h102,      N, N, N,   N, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, Y, 32'h40,       Y, Y, N,   N, 32'h0,        N, 32'h0,        32'h0,        Y));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, N,   N, 32'h0,        N, 32'h0,        32'h0,        Y));
    tbl.push_back(R(Y, N, N, 32'h0,        N, N, N,   N, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, Y,   Y, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        N, Y, N,   N, 32'h4,        Y, 32'h0,        32'h4,        N));
    tbl.push_back(R(N, N, Y, 32'h203,      N, N, N,   Y, 32'h4,        N, 32'h0,        32'h4,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, N, N,   Y, 32'h4,        N, 32'h0,        32'h4,        N));
    tbl.push_back(R(N, N, Y, 32'h0,        Y, Y, N,   N, 32'h4,        N, 32'h0,        32'h4,        Y));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, N,   N, 32'h4,        N, 32'h0,        32'h4,        Y));
    // PC wrap from 0xFFFFFFFC
    tbl.push_back(R(Y, Y, Y, 32'hFFFFFFFC, N, N, N,   N, 32'h0,        N, 32'h0,        32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        N, N, N,   N, 32'hFFFFFFFC, N, 32'h0,        32'hFFFFFFFC, N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, Y,   Y, 32'hFFFFFFFC, N, 32'h0,        32'hFFFFFFFC, N));
    tbl.push_back(R(N, N, N, 32'h0,        N, Y, N,   N, 32'h0,        Y, 32'hFFFFFFFC, 32'h0,        N));
    tbl.push_back(R(N, N, N, 32'h0,        Y, Y, Y,   Y, 32'h0,        N, 32'hFFFFFFFC, 32'h0,        N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, Y, N,   N, 32'h4,        Y, 32'h0,        32'h4,        N));
    tbl.push_back(R(N, Y, N, 32'h0,        N, N, N,   N, 32'h4,        N, 32'h0,        32'h4,        N));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      sb_t  e;
      v = tbl[i];
      if (v.rst) do_reset();
      chk($sformatf("v%0d_req", i), mif.imem_req, v.req);
      chk($sformatf("v%0d_addr", i), mif.imem_addr, v.addr);
      chk($sformatf("v%0d_valid", i), instr_valid, v.valid);
      chk($sformatf("v%0d_instr_pc", i), instr_pc, v.ipc);
      chk($sformatf("v%0d_pc", i), pc, v.pc);
      chk($sformatf("v%0d_fault", i), fault, v.fault);
      if (v.valid) chk($sformatf("v%0d_instr", i), instr, mem_word(v.ipc));
      observe();
      stall         = v.stall;
      branch_taken  = v.bt;
      branch_target = v.tgt;
      rdy           = v.rdy;
      decode_ready  = v.dr;
      if (v.push) begin
        e.pc   = v.addr;
        e.word = mem_word(v.addr);
        sb.push_back(e);
      end
      @(negedge clk);
    end

    // Reset asserted in the middle of an outstanding fetch drops the request at once.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80; rdy = 1'b0;
    @(negedge clk);
    stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    chk("midrst_pre_req", mif.imem_req, 1);
    chk("midrst_pre_addr", mif.imem_addr, 32'h80);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", mif.imem_req, 0);
    chk("midrst_addr", mif.imem_addr, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    prev_valid = 1'b0;
    chk("midrst_idle_req", mif.imem_req, 0);
    @(negedge clk);
    chk("midrst_refetch_req", mif.imem_req, 1);
    chk("midrst_refetch_addr", mif.imem_addr, 32'h0);
    observe();
    chk("sb_final_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
